// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_CNT_W     = $clog2(UART_DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    WAIT_FIN,
    DISCARD
  } rx_state_e;
endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with wrap-bit pointers; head is visible combinationally.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         sysclk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         full, do_push, do_pop;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign push_rdy = !full || do_pop;
  assign do_push  = push && push_rdy;
  assign head_dat = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = push_dat;
      wr_d = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/uart_rx_deframer.sv
// UART RX deframer: start detect, per-tick sampling, byte commit one cycle after baud_finish.
// Optional receive FIFO under UART_RX_FIFO_EN; otherwise a single sticky holding register.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       rx,
  input  logic       baud_tick,
  input  logic       baud_finish,
  input  logic       baud_status,
  output logic       baud_trigger,
  output logic       baud_enable,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_overrun,
  output logic       rx_busy
);
  logic [SYNC_STAGES-1:0]    sync_q, sync_d;
  logic                      prev_q, prev_d;
  logic                      rx_s, fall;
  rx_state_e                 state_q, state_d;
  logic [UART_CNT_W-1:0]     cnt_q, cnt_d;
  logic [UART_DATA_BITS-1:0] sr_q, sr_d;
  logic                      trig_q, trig_d;
  logic                      commit;
  logic                      ovr_q, ovr_d;

  assign rx_s         = sync_q[SYNC_STAGES-1];
  assign fall         = prev_q && !rx_s;
  assign baud_trigger = trig_q;
  assign baud_enable  = rx_en;
  assign rx_busy      = (state_q != IDLE);
  assign rx_overrun   = ovr_q;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], rx};
    prev_d  = rx_s;
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    trig_d  = 1'b0;
    commit  = 1'b0;
    // Finish outside WAIT_FIN/DISCARD means the generator lost sync: abandon the frame.
    unique case (state_q)
      IDLE: begin
        if (fall && rx_en && !baud_status) begin
          trig_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (baud_finish) begin
          state_d = IDLE;
        end else if (baud_tick) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            state_d = DISCARD;
          end
        end
      end
      DATA: begin
        if (baud_finish) begin
          state_d = IDLE;
        end else if (baud_tick) begin
          sr_d  = {rx_s, sr_q[UART_DATA_BITS-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == UART_CNT_W'(UART_DATA_BITS - 1)) state_d = WAIT_FIN;
        end
      end
      WAIT_FIN: begin
        if (baud_finish) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        if (baud_finish) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  logic push_rdy, fifo_empty;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(UART_DATA_BITS)) u_fifo (
    .sysclk   (sysclk),
    .reset    (reset),
    .push     (commit),
    .push_dat (sr_q),
    .push_rdy (push_rdy),
    .pop      (rx_read),
    .head_dat (rx_data),
    .empty    (fifo_empty)
  );

  assign rx_avail = !fifo_empty;

  always_comb begin
    ovr_d = ovr_q;
    if (rx_read) ovr_d = 1'b0;
    if (commit && !push_rdy) ovr_d = 1'b1;
  end
`else
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      avail_q, avail_d;

  assign rx_data  = data_q;
  assign rx_avail = avail_q;

  // A read coinciding with a commit consumes the old byte, so no overrun.
  always_comb begin
    data_d  = data_q;
    avail_d = avail_q;
    ovr_d   = ovr_q;
    if (rx_read && avail_q) begin
      avail_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (commit) begin
      data_d  = sr_q;
      avail_d = 1'b1;
      if (avail_q && !rx_read) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      data_q  <= '0;
      avail_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      avail_q <= avail_d;
    end
  end
`endif

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      trig_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      trig_q  <= trig_d;
      ovr_q   <= ovr_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer with a behavioural baud generator (16-cycle half-bit).
module tb_uart_rx_deframer;
  logic       sysclk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_en = 1'b1;
  logic       rx = 1'b1;
  logic       baud_tick = 1'b0;
  logic       baud_finish = 1'b0;
  logic       baud_status = 1'b0;
  logic       rx_read = 1'b0;
  logic       baud_trigger, baud_enable;
  logic [7:0] rx_data;
  logic       rx_avail, rx_overrun, rx_busy;

  int errors = 0;
  int checks = 0;
  int trig_cnt = 0;
  int t0;
  bit seen;
  logic [7:0] d_after;
  logic a_at_fin, a_after, o_after;

  uart_rx_deframer #(.SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .rx_en        (rx_en),
    .rx           (rx),
    .baud_tick    (baud_tick),
    .baud_finish  (baud_finish),
    .baud_status  (baud_status),
    .baud_trigger (baud_trigger),
    .baud_enable  (baud_enable),
    .rx_read      (rx_read),
    .rx_data      (rx_data),
    .rx_avail     (rx_avail),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  always #5 sysclk = ~sysclk;

  // Generator model: first tick 16 cycles after trigger, then every 32, finish 32 after last tick.
  initial begin
    forever begin
      @(negedge sysclk);
      if (baud_trigger) begin
        baud_status = 1'b1;
        repeat (15) @(negedge sysclk);
        baud_tick = 1'b1;
        @(negedge sysclk);
        baud_tick = 1'b0;
        for (int b = 0; b < 8; b++) begin
          repeat (31) @(negedge sysclk);
          baud_tick = 1'b1;
          @(negedge sysclk);
          baud_tick = 1'b0;
        end
        repeat (31) @(negedge sysclk);
        baud_finish = 1'b1;
        @(negedge sysclk);
        baud_finish = 1'b0;
        baud_status = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge sysclk);
      #1;
      if (baud_trigger) trig_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_finish(output bit found);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (baud_finish) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic do_read();
    rx_read = 1'b1;
    step();
    rx_read = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rd_at_fin);
    bit found;
    rx = 1'b0;
    repeat (32) step();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (32) step();
    end
    rx = 1'b1;
    wait_finish(found);
    chk("finish_seen", {31'd0, found}, 32'd1);
    a_at_fin = rx_avail;
    if (rd_at_fin) rx_read = 1'b1;
    step();
    rx_read = 1'b0;
    d_after = rx_data;
    a_after = rx_avail;
    o_after = rx_overrun;
    repeat (20) step();
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_trigger", {31'd0, baud_trigger}, 32'd0);
    chk("rst_data", {24'd0, rx_data}, 32'h00);
    chk("rst_avail", {31'd0, rx_avail}, 32'd0);
    chk("rst_overrun", {31'd0, rx_overrun}, 32'd0);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    chk("rst_enable", {31'd0, baud_enable}, 32'd1);
    reset = 1'b1;
    repeat (5) step();

    // 8'hA5 frame, then read
    t0 = trig_cnt;
    send_byte(8'hA5, 1'b0);
    chk("a5_trig_count", trig_cnt - t0, 32'd1);
    chk("a5_avail_at_finish", {31'd0, a_at_fin}, 32'd0);
    chk("a5_data", {24'd0, d_after}, 32'hA5);
    chk("a5_avail", {31'd0, a_after}, 32'd1);
    chk("a5_busy_after", {31'd0, rx_busy}, 32'd0);
    do_read();
    chk("a5_avail_read", {31'd0, rx_avail}, 32'd0);

    // 3-cycle low glitch: false start goes to DISCARD
    t0 = trig_cnt;
    rx = 1'b0;
    repeat (3) step();
    rx = 1'b1;
    repeat (30) step();
    chk("gl_trig_count", trig_cnt - t0, 32'd1);
    chk("gl_busy_discard", {31'd0, rx_busy}, 32'd1);
    wait_finish(seen);
    chk("gl_finish_seen", {31'd0, seen}, 32'd1);
    step();
    chk("gl_busy_after", {31'd0, rx_busy}, 32'd0);
    chk("gl_avail", {31'd0, rx_avail}, 32'd0);
    repeat (5) step();

    // rx_en low blocks new starts
    rx_en = 1'b0;
    step();
    chk("en_baud_enable", {31'd0, baud_enable}, 32'd0);
    t0 = trig_cnt;
    rx = 1'b0;
    repeat (6) step();
    rx = 1'b1;
    repeat (6) step();
    chk("en_no_trig", trig_cnt - t0, 32'd0);
    chk("en_busy", {31'd0, rx_busy}, 32'd0);
    rx_en = 1'b1;
    repeat (3) step();

    // Back-to-back 01, 80 with no read
    send_byte(8'h01, 1'b0);
    chk("b2b_first_data", {24'd0, d_after}, 32'h01);
    chk("b2b_first_ovr", {31'd0, o_after}, 32'd0);
    send_byte(8'h80, 1'b0);
`ifdef UART_RX_FIFO_EN
    chk("b2b_fifo_ovr", {31'd0, o_after}, 32'd0);
    chk("b2b_fifo_head0", {24'd0, rx_data}, 32'h01);
    do_read();
    chk("b2b_fifo_head1", {24'd0, rx_data}, 32'h80);
    do_read();
    chk("b2b_fifo_empty", {31'd0, rx_avail}, 32'd0);
`else
    chk("b2b_data", {24'd0, d_after}, 32'h80);
    chk("b2b_ovr", {31'd0, o_after}, 32'd1);
    chk("b2b_avail", {31'd0, a_after}, 32'd1);
    do_read();
    chk("b2b_avail_read", {31'd0, rx_avail}, 32'd0);
    chk("b2b_ovr_read", {31'd0, rx_overrun}, 32'd0);
`endif

    // Read coinciding with commit of 3C while 77 is pending
    send_byte(8'h77, 1'b0);
    chk("rc_pending", {31'd0, a_after}, 32'd1);
    send_byte(8'h3C, 1'b1);
    chk("rc_data", {24'd0, d_after}, 32'h3C);
    chk("rc_avail", {31'd0, a_after}, 32'd1);
    chk("rc_ovr", {31'd0, o_after}, 32'd0);

    // Reset mid-DATA while the generator stays busy
    rx = 1'b0;
    repeat (32) step();
    rx = 1'b1;
    repeat (64) step();
    chk("mr_busy_before", {31'd0, rx_busy}, 32'd1);
    reset = 1'b0;
    step();
    step();
    chk("mr_trigger", {31'd0, baud_trigger}, 32'd0);
    chk("mr_data", {24'd0, rx_data}, 32'h00);
    chk("mr_avail", {31'd0, rx_avail}, 32'd0);
    chk("mr_overrun", {31'd0, rx_overrun}, 32'd0);
    chk("mr_busy", {31'd0, rx_busy}, 32'd0);
    reset = 1'b1;
    t0 = trig_cnt;
    rx = 1'b0;
    repeat (6) step();
    rx = 1'b1;
    repeat (6) step();
    chk("mr_no_trig_busy_gen", trig_cnt - t0, 32'd0);
    chk("mr_idle", {31'd0, rx_busy}, 32'd0);
    for (int i = 0; i < 400; i++) begin
      if (!baud_status) break;
      step();
    end
    chk("mr_gen_idle", {31'd0, baud_status}, 32'd0);
    repeat (5) step();
    send_byte(8'h5A, 1'b0);
    chk("mr_trig_count", trig_cnt - t0, 32'd1);
    chk("mr_data_5a", {24'd0, d_after}, 32'h5A);
    chk("mr_avail_5a", {31'd0, a_after}, 32'd1);
    do_read();

`ifdef UART_RX_FIFO_EN
    // Overfill depth-4 FIFO with 10..14
    chk("ff_empty", {31'd0, rx_avail}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h10 + 8'(i), 1'b0);
      if (i == 3) chk("ff_no_ovr_at_full", {31'd0, o_after}, 32'd0);
    end
    chk("ff_ovr", {31'd0, rx_overrun}, 32'd1);
    chk("ff_head10", {24'd0, rx_data}, 32'h10);
    do_read();
    chk("ff_ovr_cleared", {31'd0, rx_overrun}, 32'd0);
    chk("ff_head11", {24'd0, rx_data}, 32'h11);
    do_read();
    chk("ff_head12", {24'd0, rx_data}, 32'h12);
    do_read();
    chk("ff_head13", {24'd0, rx_data}, 32'h13);
    do_read();
    chk("ff_drained", {31'd0, rx_avail}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
